// File: rtl/lcd_pkg.sv
// Shared types, command codes and default 100 MHz timing for the HD44780 4-bit byte transmitter.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP_H,
    ST_PULSE_H,
    ST_GAP_H,
    ST_SETUP_L,
    ST_PULSE_L,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;

  localparam int unsigned DEF_SETUP_CYC     = 4;
  localparam int unsigned DEF_PULSE_CYC     = 50;
  localparam int unsigned DEF_GAP_CYC       = 100;
  localparam int unsigned DEF_EXEC_CYC      = 4000;
  localparam int unsigned DEF_LONG_EXEC_CYC = 200000;
  localparam int unsigned DEF_INIT_CYC      = 500000;
  localparam int unsigned DEF_POWERUP_CYC   = 1500000;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is high on the cycle the count reaches 1, so a load of N spans N cycles.
module lcd_delay_timer #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             clock,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  // No separate reset: the owner reloads the counter on its own reset cycle.
  always_ff @(posedge clock) begin
    if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == WIDTH'(1));

endmodule

// File: rtl/lcd_byte_tx.sv
// HD44780 4-bit-mode byte transmitter: valid/ready byte in, timed RS/E/D7..D4 strobes out.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
  parameter int unsigned GAP_CYC       = DEF_GAP_CYC,
  parameter int unsigned EXEC_CYC      = DEF_EXEC_CYC,
  parameter int unsigned LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int unsigned INIT_CYC      = DEF_INIT_CYC,
  parameter int unsigned POWERUP_CYC   = DEF_POWERUP_CYC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       in_nibble_only,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       busy
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(GAP_CYC, EXEC_CYC)),
                                          max_u(max_u(LONG_EXEC_CYC, INIT_CYC), POWERUP_CYC));
  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  lcd_state_t    state_reg;
  logic [7:0]    data_reg;
  logic          nib_reg;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_done;
  logic          accept;
  logic [CW-1:0] byte_wait;

  assign accept    = in_valid && in_ready;
  assign byte_wait = is_long_cmd(lcd_rs, data_reg) ? CW'(LONG_EXEC_CYC) : CW'(EXEC_CYC);

  // Timer reload happens on the same edge as the state change it times.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (reset) begin
      timer_load = 1'b1;
      timer_val  = CW'(POWERUP_CYC);
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          timer_load = 1'b1;
          timer_val  = CW'(SETUP_CYC);
        end
        ST_SETUP_H, ST_SETUP_L: if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = CW'(PULSE_CYC);
        end
        ST_PULSE_H: if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = nib_reg ? CW'(INIT_CYC) : CW'(GAP_CYC);
        end
        ST_GAP_H: if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = CW'(SETUP_CYC);
        end
        ST_PULSE_L: if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = byte_wait;
        end
        default: ;
      endcase
    end
  end

  lcd_delay_timer #(.WIDTH(CW)) u_timer (
    .clock    (clock),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_POWERUP;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= 4'h0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
      data_reg  <= 8'h00;
      nib_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_POWERUP: if (timer_done) begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        ST_IDLE: if (accept) begin
          state_reg <= ST_SETUP_H;
          in_ready  <= 1'b0;
          busy      <= 1'b1;
          lcd_rs    <= in_rs;
          lcd_d     <= in_data[7:4];
          data_reg  <= in_data;
          nib_reg   <= in_nibble_only;
        end
        ST_SETUP_H: if (timer_done) begin
          state_reg <= ST_PULSE_H;
          lcd_e     <= 1'b1;
        end
        ST_PULSE_H: if (timer_done) begin
          state_reg <= nib_reg ? ST_WAIT : ST_GAP_H;
          lcd_e     <= 1'b0;
        end
        // Low nibble only appears after the gap, never on the falling-E cycle.
        ST_GAP_H: if (timer_done) begin
          state_reg <= ST_SETUP_L;
          lcd_d     <= data_reg[3:0];
        end
        ST_SETUP_L: if (timer_done) begin
          state_reg <= ST_PULSE_L;
          lcd_e     <= 1'b1;
        end
        ST_PULSE_L: if (timer_done) begin
          state_reg <= ST_WAIT;
          lcd_e     <= 1'b0;
        end
        ST_WAIT: if (timer_done) begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_POWERUP;
          lcd_e     <= 1'b0;
        end
      endcase
    end
  end

endmodule
